// File: rtl/bin2bcd_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq_pkg
// Brief    : Shared constants and FSM state type for the binary-to-BCD block.
// Revision : 1.0
// ============================================================================
package bin2bcd_seq_pkg;

  localparam int BIN_W   = 21;
  localparam int NDIG    = 6;
  localparam int MAX_VAL = 1999999;
  localparam int ITER    = 21;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq_if
// Brief    : Request/result bundle between a converter client and bin2bcd_seq.
// Revision : 1.0
// ============================================================================
interface bin2bcd_seq_if;
  import bin2bcd_seq_pkg::*;

  logic             start;
  logic [BIN_W-1:0] bin_in;
  logic             busy;
  logic             done;
  logic             ovf;
  logic             d0;
  logic [3:0]       d1;
  logic [3:0]       d2;
  logic [3:0]       d3;
  logic [3:0]       d4;
  logic [3:0]       d5;
  logic [3:0]       d6;

  modport master (
    output start, bin_in,
    input  busy, done, ovf, d0, d1, d2, d3, d4, d5, d6
  );

  modport slave (
    input  start, bin_in,
    output busy, done, ovf, d0, d1, d2, d3, d4, d5, d6
  );

endinterface
`default_nettype wire

// File: rtl/bin2bcd_seq_bcd_add3.sv
`default_nettype none
// ============================================================================
// Module   : bcd_add3
// Brief    : Double-dabble nibble correction: add 3 when the nibble is >= 5.
// Revision : 1.0
// ============================================================================
module bcd_add3 (
  input  wire logic [3:0] din,
  output logic      [3:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'd5) dout = din + 4'd3;
  end

endmodule
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Brief    : Sequential shift-and-add-3 binary to BCD converter, saturating.
// Revision : 1.0
// ============================================================================
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int BIN_W = bin2bcd_seq_pkg::BIN_W,
  parameter int NDIG  = bin2bcd_seq_pkg::NDIG
) (
  input  wire logic       clk,
  input  wire logic       rst,
  bin2bcd_seq_if.slave    bus
);

  localparam int SCR_W = 4 * NDIG;
  localparam int CNT_W = $clog2(ITER + 1);
  localparam logic [BIN_W-1:0] C_MAX = BIN_W'(MAX_VAL);
  localparam logic [SCR_W:0]   C_SAT = {1'b1, {NDIG{4'd9}}};

  state_t             r_state;
  logic [BIN_W-1:0]   r_bin;
  logic               r_lead;
  logic [SCR_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sat;
  logic               r_busy;
  logic               r_done;
  logic               r_ovf;
  logic [SCR_W:0]     r_digits;
  logic [SCR_W-1:0]   w_adj;

  // The lead bit is deliberately outside the correction network.
  generate
    for (genvar g = 0; g < NDIG; g++) begin : g_add3
      bcd_add3 u_add3 (
        .din  (r_bcd[4*g +: 4]),
        .dout (w_adj[4*g +: 4])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_bin    <= '0;
      r_lead   <= 1'b0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_sat    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_digits <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_bin   <= bus.bin_in;
            r_lead  <= 1'b0;
            r_bcd   <= '0;
            r_cnt   <= CNT_W'(ITER);
            r_sat   <= (bus.bin_in > C_MAX);
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          {r_lead, r_bcd, r_bin} <= {w_adj, r_bin, 1'b0};
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= DONE;
        end
        DONE: begin
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_ovf    <= r_sat;
          r_digits <= r_sat ? C_SAT : {r_lead, r_bcd};
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.ovf  = r_ovf;
  assign bus.d0   = r_digits[SCR_W];
  assign bus.d1   = r_digits[23:20];
  assign bus.d2   = r_digits[19:16];
  assign bus.d3   = r_digits[15:12];
  assign bus.d4   = r_digits[11:8];
  assign bus.d5   = r_digits[7:4];
  assign bus.d6   = r_digits[3:0];

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin2bcd_seq
// Brief    : Directed and random checks of bin2bcd_seq against a decimal model.
// Revision : 1.0
// ============================================================================
module tb_bin2bcd_seq;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  bin2bcd_seq_if bif ();

  bin2bcd_seq u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected {d0,d1..d6} straight from decimal arithmetic, saturated above the max.
  function automatic logic [24:0] ref_digits(input int unsigned v);
    logic [24:0] r;
    int unsigned x;
    x = (v > 1999999) ? 1999999 : v;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'((x / (10 ** i)) % 10);
    end
    r[24] = (x >= 1000000);
    return r;
  endfunction

  function automatic logic [24:0] obs_digits();
    return {bif.d0, bif.d1, bif.d2, bif.d3, bif.d4, bif.d5, bif.d6};
  endfunction

  // One conversion; s1/s2 = edge numbers for extra start pulses, r = edge for reset (0 = none).
  task automatic conv(input logic [20:0] v, input int s1, input int s2, input int r, input string tag);
    int lat;
    int bcnt;
    lat  = 0;
    bcnt = 0;
    @(negedge clk);
    bif.bin_in = v;
    bif.start  = 1'b1;
    @(posedge clk);
    #1;
    bif.start  = 1'b0;
    bif.bin_in = 21'($urandom);
    if (bif.busy) bcnt++;
    for (int n = 1; n <= 40; n++) begin
      bif.start = (n == s1) || (n == s2);
      rst       = (n == r);
      @(posedge clk);
      #1;
      if (bif.busy) bcnt++;
      if (bif.done) begin
        lat = n;
        break;
      end
    end
    bif.start = 1'b0;
    rst       = 1'b0;
    if (r != 0) begin
      check({tag, "_rst_nodone"}, 32'(lat), 32'd0);
      check({tag, "_rst_busy"}, 32'(bif.busy), 32'd0);
      check({tag, "_rst_digits"}, 32'(obs_digits()), 32'd0);
      check({tag, "_rst_ovf"}, 32'(bif.ovf), 32'd0);
    end else begin
      check({tag, "_latency"}, 32'(lat), 32'd22);
      check({tag, "_busy_cycles"}, 32'(bcnt), 32'd22);
      check({tag, "_digits"}, 32'(obs_digits()), 32'(ref_digits(32'(v))));
      check({tag, "_ovf"}, 32'(bif.ovf), 32'(v > 21'd1999999));
      @(posedge clk);
      #1;
      check({tag, "_done_width"}, 32'(bif.done), 32'd0);
      check({tag, "_hold"}, 32'(obs_digits()), 32'(ref_digits(32'(v))));
    end
  endtask

  task automatic quiet(input int cycles, input string tag);
    int pulses;
    pulses = 0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk);
      #1;
      if (bif.done) pulses++;
    end
    check({tag, "_no_done"}, 32'(pulses), 32'd0);
    check({tag, "_idle_busy"}, 32'(bif.busy), 32'd0);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    bif.start  = 1'b0;
    bif.bin_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(bif.busy), 32'd0);
    check("reset_done", 32'(bif.done), 32'd0);
    check("reset_ovf", 32'(bif.ovf), 32'd0);
    check("reset_digits", 32'(obs_digits()), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    conv(21'd0, 0, 0, 0, "zero");
    conv(21'd1234567, 0, 0, 0, "v1234567");
    conv(21'd1999999, 0, 0, 0, "max");
    conv(21'd2097151, 0, 0, 0, "allones");
    conv(21'd2000000, 0, 0, 0, "ovf");
    conv(21'd654321, 0, 0, 10, "midrst");
    conv(21'd654321, 0, 0, 0, "after_rst");
    conv(21'd99995, 5, 22, 0, "ignore_start");
    quiet(30, "ignore_start");

    // Reset and start on the same edge: reset must win.
    @(negedge clk);
    rst        = 1'b1;
    bif.start  = 1'b1;
    bif.bin_in = 21'd777777;
    @(negedge clk);
    rst        = 1'b0;
    bif.start  = 1'b0;
    quiet(30, "rst_start");
    check("rst_start_digits", 32'(obs_digits()), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      conv(21'($urandom), 0, 0, 0, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
